// File: rtl/multiplier_pkg.sv
// Shared encodings for the radix-2 Booth multiplier sequencing controller.
package multiplier_pkg;

  localparam int STATE_W = 3;
  localparam int COUNT_W = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_ARITH = 3'b010,
    ST_SHIFT = 3'b011,
    ST_DONE  = 3'b100
  } state_t;

  // {q0, q_-1} pairs that call for an arithmetic step
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mul_ctrl_ns.sv
// Combinational next-state, next-count and strobe decode for the Booth controller.
module mul_ctrl_ns
  import multiplier_pkg::*;
#(
  parameter int unsigned N_ITER = 64
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic               op_start_i,
  input  logic               op_clear_i,
  input  logic [1:0]         booth_bits_i,
  output logic [STATE_W-1:0] state_d_o,
  output logic [COUNT_W-1:0] count_d_o,
  output logic               dp_load_o,
  output logic               dp_add_o,
  output logic               dp_sub_o,
  output logic               dp_shift_o,
  output logic               busy_o,
  output logic               op_done_o
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(N_ITER);

  logic [COUNT_W-1:0] count_inc;
  assign count_inc = count_i + 7'd1;

  // Illegal codes fall to the default arm and recover to IDLE on the next edge.
  always_comb begin
    state_d_o  = state_i;
    count_d_o  = count_i;
    dp_load_o  = 1'b0;
    dp_add_o   = 1'b0;
    dp_sub_o   = 1'b0;
    dp_shift_o = 1'b0;
    busy_o     = 1'b0;
    op_done_o  = 1'b0;

    case (state_i)
      ST_IDLE: begin
        count_d_o = '0;
        if (op_start_i) state_d_o = ST_LOAD;
      end
      ST_LOAD: begin
        dp_load_o = 1'b1;
        busy_o    = 1'b1;
        count_d_o = '0;
        state_d_o = ST_ARITH;
      end
      ST_ARITH: begin
        busy_o    = 1'b1;
        dp_add_o  = (booth_bits_i == BOOTH_ADD);
        dp_sub_o  = (booth_bits_i == BOOTH_SUB);
        state_d_o = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_o     = 1'b1;
        dp_shift_o = 1'b1;
        count_d_o  = count_inc;
        state_d_o  = (count_inc == LAST_COUNT) ? ST_DONE : ST_ARITH;
      end
      ST_DONE: begin
        op_done_o = 1'b1;
        if (op_start_i) begin
          state_d_o = ST_LOAD;
          count_d_o = '0;
        end
      end
      default: begin
        state_d_o = ST_IDLE;
        count_d_o = '0;
      end
    endcase

    // Clear aborts from any state and beats a simultaneous start.
    if (op_clear_i) begin
      state_d_o = ST_IDLE;
      count_d_o = '0;
    end
  end

endmodule

// File: rtl/multiplier_ctrl.sv
// Booth multiplier sequencing controller: state and iteration-count registers.
module multiplier_ctrl
  import multiplier_pkg::*;
#(
  parameter int unsigned N_ITER = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [1:0]         booth_bits,
  output logic               dp_load,
  output logic               dp_add,
  output logic               dp_sub,
  output logic               dp_shift,
  output logic               busy,
  output logic               op_done,
  output logic [COUNT_W-1:0] count
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  mul_ctrl_ns #(
    .N_ITER(N_ITER)
  ) u_ns (
    .state_i     (state_q),
    .count_i     (count_q),
    .op_start_i  (op_start),
    .op_clear_i  (op_clear),
    .booth_bits_i(booth_bits),
    .state_d_o   (state_d),
    .count_d_o   (count_d),
    .dp_load_o   (dp_load),
    .dp_add_o    (dp_add),
    .dp_sub_o    (dp_sub),
    .dp_shift_o  (dp_shift),
    .busy_o      (busy),
    .op_done_o   (op_done)
  );

  // Reset parks the controller in IDLE, which also decodes every strobe to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: doc/multiplier_ctrl.md
# multiplier_ctrl

Sequencing controller for the iterative radix-2 Booth multiplier datapath. It accepts a start command and issues load, add, subtract and shift strobes to the datapath. The datapath returns the multiplier LSB pair each iteration. The controller runs a fixed number of iterations, then holds a done indication. It sits between the bus-facing command logic and the multiplier datapath, and owns the 3-bit state register and the 7-bit iteration count.

## Interface
- N_ITER, default 64: number of Booth iterations per operation. Legal range is 1..127.
- clk  in  1  single clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_start  in  1  start request. Sampled only in IDLE and DONE.
- op_clear  in  1  abort/clear. Highest priority below reset.
- booth_bits  in  2  {q0, q_-1} from the datapath multiplier register.
- dp_load  out  1  load operands and clear the accumulator (one cycle).
- dp_add  out  1  accumulator += multiplicand.
- dp_sub  out  1  accumulator -= multiplicand.
- dp_shift  out  1  arithmetic right shift of {acc, q, q_-1}.
- busy  out  1  high in LOAD, ARITH and SHIFT.
- op_done  out  1  high in DONE.
- count  out  7  completed iterations.

## Operation
- States, 3-bit:
  - IDLE=000
  - LOAD=001
  - ARITH=010
  - SHIFT=011
  - DONE=100
  - Codes 101–111 are illegal and go to IDLE on the next edge.
- Transitions:
  - IDLE: op_start goes to LOAD; otherwise stay in IDLE.
  - LOAD: go to ARITH.
  - ARITH: go to SHIFT.
  - SHIFT: if count+1 == N_ITER, go to DONE; otherwise go to ARITH.
  - DONE: op_start goes to LOAD; otherwise hold DONE indefinitely.
- op_clear high at an edge, in any state, goes to IDLE and sets count=0. It overrides op_start.
- op_start is ignored while busy.
- Count rules:
  - Set to 0 in IDLE and LOAD.
  - Incremented by 1 at each SHIFT exit edge.
  - Holds N_ITER throughout DONE.
  - 7-bit unsigned. It never wraps because N_ITER ≤ 127.
- Output decode:
  - dp_load: Moore, LOAD only.
  - dp_shift: Moore, SHIFT only.
  - busy and op_done: Moore, from state.
  - dp_add: Mealy, ARITH with booth_bits == 01.
  - dp_sub: Mealy, ARITH with booth_bits == 10.
  - booth_bits 00 or 11 produces no arithmetic strobe.
  - dp_add and dp_sub are never high together.
  - No strobe is active outside its state.
- Reset:
  - Asynchronous; forces IDLE and count=0 immediately, including mid-operation.
  - While reset is high, every output is 0.
  - After release, the first edge evaluates from IDLE.

## Timing
- Reset value of all outputs: 0.
- Take op_start sampled in IDLE at edge E0:
  - dp_load is high in the cycle after E0.
  - Iteration i (1..N_ITER) has ARITH in the cycle after edge E0+2i−1 and SHIFT in the cycle after edge E0+2i.
  - DONE is entered at edge E0+2·N_ITER+1. op_done rises at that edge; latency is 2·N_ITER+1 cycles (129 for N_ITER=64).
- Restart from DONE at edge Ed: op_done falls and LOAD starts at Ed, with the same latency as above.
- op_clear sampled at edge Ec: busy, op_done and count are all 0 after Ec. No partial op_done pulse.

## Structure
- Shared package multiplier_pkg holds:
  - state encodings ST_IDLE..ST_DONE and the state width 3;
  - count width 7;
  - Booth codes BOOTH_ADD=2'b01 and BOOTH_SUB=2'b10.
- One natural sub-module, mul_ctrl_ns: purely combinational next-state, next-count and output decode.
- multiplier_ctrl instantiates mul_ctrl_ns and holds the async active-high state and count registers.

## Test plan
- reset pulse during ARITH at iteration 10: all outputs 0 while reset is high; after release, state is IDLE, count=0, and an op_start 2 cycles later runs a full operation.
- N_ITER=64, booth_bits held 01, op_start for one cycle:
  - exactly 1 dp_load;
  - 64 dp_add and 64 dp_shift pulses, alternating;
  - op_done high 129 edges after the start edge;
  - count=64 in DONE.
- booth_bits cycling 10,00,11,01 per iteration: dp_sub only on 10, dp_add only on 01, none on 00/11; never both.
- op_clear asserted in SHIFT of iteration 20: IDLE next edge, count=0, busy=0, op_done never rises; op_start held high during busy earlier had no effect.
- In DONE, op_start: LOAD next edge, op_done falls. op_start and op_clear together in DONE: IDLE, no load.
- N_ITER=1: op_done 3 edges after start, count=1. Force illegal state 110: IDLE next edge.
